// File: rtl/fft_ctrl_pkg.sv
// Shared types and default sizing for the FFT frame sequencer and its peak tracker.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCapture,
    StStream,
    StScan,
    StDone
  } ctrl_state_e;

  localparam int unsigned DATA_NUM_DEF  = 128;
  localparam int unsigned FFT_WIDTH_DEF = 24;

  localparam int unsigned BIN_W = $clog2(DATA_NUM_DEF);
  localparam int unsigned MAG_W = 2 * FFT_WIDTH_DEF + 1;

  // Positive half-spectrum excluding DC and Nyquist.
  localparam int unsigned HALF_LO = 1;

  function automatic int unsigned half_hi(input int unsigned n);
    return n / 2 - 1;
  endfunction

  localparam int unsigned HALF_HI = half_hi(DATA_NUM_DEF);

endpackage

// File: rtl/fft_peak_tracker.sv
// Two-stage magnitude/compare pipeline: stage 1 registers re^2+im^2 with its bin,
// stage 2 keeps the strictly-largest half-spectrum bin seen since the last clear.
module fft_peak_tracker
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned DATA_NUM  = DATA_NUM_DEF,
  parameter int unsigned FFT_WIDTH = FFT_WIDTH_DEF,
  localparam int unsigned BinW     = $clog2(DATA_NUM),
  localparam int unsigned MagW     = 2 * FFT_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        tvalid_i,
  input  logic                        tlast_i,
  input  logic signed [FFT_WIDTH-1:0] re_i,
  input  logic signed [FFT_WIDTH-1:0] im_i,
  output logic        [BinW-1:0]      peak_bin_o,
  output logic        [MagW-1:0]      peak_mag_o,
  output logic                        frame_end_o,
  output logic                        tlast_err_o
);

  logic signed [2*FFT_WIDTH-1:0] re_x, im_x, re_sq, im_sq;
  logic        [MagW-1:0]        mag;

  logic [BinW-1:0] bin_q;
  logic            s1_vld_q, s1_last_q;
  logic [BinW-1:0] s1_bin_q;
  logic [MagW-1:0] s1_mag_q;
  logic [BinW-1:0] peak_bin_q, peak_bin_d;
  logic [MagW-1:0] peak_mag_q, peak_mag_d;
  logic            in_half;

  assign re_x  = (2 * FFT_WIDTH)'(re_i);
  assign im_x  = (2 * FFT_WIDTH)'(im_i);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign mag   = MagW'($unsigned(re_sq)) + MagW'($unsigned(im_sq));

  assign in_half = (s1_bin_q >= BinW'(HALF_LO)) && (s1_bin_q <= BinW'(half_hi(DATA_NUM)));

  // Strict compare keeps the lowest bin on ties since bins arrive in ascending order.
  always_comb begin
    peak_bin_d = peak_bin_q;
    peak_mag_d = peak_mag_q;
    if (s1_vld_q && in_half && (s1_mag_q > peak_mag_q)) begin
      peak_bin_d = s1_bin_q;
      peak_mag_d = s1_mag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      bin_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bin_q   <= '0;
      s1_mag_q   <= '0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else begin
      s1_vld_q   <= tvalid_i;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
      if (tvalid_i) begin
        bin_q     <= bin_q + 1'b1;
        s1_bin_q  <= bin_q;
        s1_mag_q  <= mag;
        s1_last_q <= tlast_i;
      end
    end
  end

  // Expose the post-compare peak so the final beat is included when the frame ends.
  assign peak_bin_o  = peak_bin_d;
  assign peak_mag_o  = peak_mag_d;
  assign frame_end_o = s1_vld_q && s1_last_q;
  assign tlast_err_o = frame_end_o && (s1_bin_q != BinW'(DATA_NUM - 1));

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: clears the sample FIFO, gates DATA_NUM ADC writes, releases the
// reader into the FFT, then reports the peak half-spectrum bin of the output frame.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned DATA_NUM   = DATA_NUM_DEF,
  parameter int unsigned FFT_WIDTH  = FFT_WIDTH_DEF,
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 4096,
  localparam int unsigned BinW      = $clog2(DATA_NUM),
  localparam int unsigned MagW      = 2 * FFT_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        continuous_i,
  input  logic                        adc_valid_i,
  output logic                        fifo_srst_o,
  output logic                        fifo_wr_en_o,
  input  logic                        fifo_full_i,
  input  logic [9:0]                  fifo_data_count_i,
  output logic                        rd_enable_o,
  input  logic                        fft_rst_done_i,
  input  logic                        fft_tvalid_i,
  input  logic                        fft_tlast_i,
  input  logic signed [FFT_WIDTH-1:0] fft_re_i,
  input  logic signed [FFT_WIDTH-1:0] fft_im_i,
  input  logic                        fft_err_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [BinW-1:0]             peak_bin_o,
  output logic [MagW-1:0]             peak_mag_o,
  output logic                        err_o
);

  localparam int unsigned CntW = BinW + 1;
  localparam int unsigned ClrW = $clog2(CLR_CYCLES) + 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT) + 1;

  ctrl_state_e     state_q;
  logic            pending_q;
  logic [ClrW-1:0] clr_cnt_q;
  logic [CntW-1:0] wr_cnt_q;
  logic [ToW-1:0]  to_cnt_q;
  logic            err_q, done_q, err_out_q;
  logic [BinW-1:0] peak_bin_q;
  logic [MagW-1:0] peak_mag_q;

  logic            active, timeout, trk_valid;
  logic [BinW-1:0] trk_peak_bin;
  logic [MagW-1:0] trk_peak_mag;
  logic            trk_frame_end, trk_tlast_err;

  assign active    = (state_q == StStream) || (state_q == StScan);
  assign timeout   = active && (to_cnt_q == ToW'(TIMEOUT - 1));
  assign trk_valid = fft_tvalid_i && active;

  assign fifo_wr_en_o = (state_q == StCapture) && adc_valid_i && (wr_cnt_q < CntW'(DATA_NUM));
  assign fifo_srst_o  = (state_q == StClear);
  assign rd_enable_o  = active;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_mag_o   = peak_mag_q;
  assign err_o        = err_out_q;

  fft_peak_tracker #(
    .DATA_NUM  (DATA_NUM),
    .FFT_WIDTH (FFT_WIDTH)
  ) u_peak_tracker (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == StClear),
    .tvalid_i    (trk_valid),
    .tlast_i     (fft_tlast_i),
    .re_i        (fft_re_i),
    .im_i        (fft_im_i),
    .peak_bin_o  (trk_peak_bin),
    .peak_mag_o  (trk_peak_mag),
    .frame_end_o (trk_frame_end),
    .tlast_err_o (trk_tlast_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      clr_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      err_out_q  <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) pending_q <= 1'b1;
          if ((pending_q || start_i) && fft_rst_done_i) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end
        end
        StClear: begin
          wr_cnt_q <= '0;
          err_q    <= 1'b0;
          if (clr_cnt_q == ClrW'(CLR_CYCLES - 1)) state_q <= StCapture;
          else clr_cnt_q <= clr_cnt_q + 1'b1;
        end
        StCapture: begin
          if (fifo_wr_en_o) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (fifo_full_i) err_q <= 1'b1;
          end
          if ((wr_cnt_q == CntW'(DATA_NUM)) && (fifo_data_count_i == 10'(DATA_NUM))) begin
            state_q  <= StStream;
            to_cnt_q <= '0;
          end
        end
        StStream, StScan: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          err_q    <= err_q | fft_err_i;
          if ((state_q == StStream) && fft_tvalid_i) state_q <= StScan;
          if (trk_frame_end || timeout) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            peak_bin_q <= trk_peak_bin;
            peak_mag_q <= trk_peak_mag;
            err_out_q  <= err_q | fft_err_i | trk_tlast_err | timeout;
          end
        end
        StDone: begin
          if (continuous_i) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end else begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: a behavioural FIFO occupancy counter and
// hand-built FFT output frames with hand-computed peak expectations.
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int unsigned N  = DATA_NUM_DEF;
  localparam int unsigned W  = FFT_WIDTH_DEF;
  localparam int unsigned TO = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, continuous_i = 1'b0, adc_valid_i = 1'b1;
  logic fifo_srst, fifo_wr_en, fifo_full_i = 1'b0, rd_enable;
  logic [9:0] fifo_data_count;
  logic fft_rst_done_i = 1'b1, fft_tvalid_i = 1'b0, fft_tlast_i = 1'b0, fft_err_i = 1'b0;
  logic signed [W-1:0] fft_re_i = '0, fft_im_i = '0;
  logic busy, done, err;
  logic [BIN_W-1:0] peak_bin;
  logic [MAG_W-1:0] peak_mag;

  int n_vec = 0;
  int n_bad = 0;
  int fifo_cnt = 0;
  int wr_pulses = 0;
  int done_cnt = 0;

  logic signed [W-1:0] re_v[N];
  logic signed [W-1:0] im_v[N];

  fft_frame_ctrl #(
    .DATA_NUM   (N),
    .FFT_WIDTH  (W),
    .CLR_CYCLES (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .continuous_i      (continuous_i),
    .adc_valid_i       (adc_valid_i),
    .fifo_srst_o       (fifo_srst),
    .fifo_wr_en_o      (fifo_wr_en),
    .fifo_full_i       (fifo_full_i),
    .fifo_data_count_i (fifo_data_count),
    .rd_enable_o       (rd_enable),
    .fft_rst_done_i    (fft_rst_done_i),
    .fft_tvalid_i      (fft_tvalid_i),
    .fft_tlast_i       (fft_tlast_i),
    .fft_re_i          (fft_re_i),
    .fft_im_i          (fft_im_i),
    .fft_err_i         (fft_err_i),
    .busy_o            (busy),
    .done_o            (done),
    .peak_bin_o        (peak_bin),
    .peak_mag_o        (peak_mag),
    .err_o             (err)
  );

  always #5 clk = ~clk;

  assign fifo_data_count = 10'(fifo_cnt);

  always @(posedge clk) begin
    if (fifo_srst) fifo_cnt <= 0;
    else if (fifo_wr_en) fifo_cnt <= fifo_cnt + 1;
    if (fifo_wr_en) wr_pulses <= wr_pulses + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin
      re_v[i] = '0;
      im_v[i] = '0;
    end
  endtask

  // Called just after a rising edge; leaves the start pulse one cycle wide.
  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Waits for the reader release, sends bins 0..last_bin, and checks the result.
  task automatic run_frame(input string tag, input int last_bin, input int err_bin,
                           input int exp_bin, input logic [63:0] exp_mag, input bit exp_err);
    int k, lat;
    k = 0;
    @(negedge clk);
    while (!rd_enable && k < 1000) begin
      k++;
      @(negedge clk);
    end
    check_eq({tag, "_rd_en"}, rd_enable, 1);
    @(posedge clk); #1;
    for (int b = 0; b <= last_bin; b++) begin
      fft_tvalid_i = 1'b1;
      fft_re_i     = re_v[b];
      fft_im_i     = im_v[b];
      fft_tlast_i  = (b == last_bin);
      fft_err_i    = (b == err_bin);
      @(posedge clk); #1;
    end
    fft_tvalid_i = 1'b0;
    fft_tlast_i  = 1'b0;
    fft_err_i    = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    check_eq({tag, "_done_lat"}, lat, 2);
    check_eq({tag, "_bin"}, peak_bin, exp_bin);
    check_eq({tag, "_mag"}, peak_mag, exp_mag);
    check_eq({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    int n, w0, d0, k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_srst", fifo_srst, 0);
    check_eq("rst_wr_en", fifo_wr_en, 0);
    check_eq("rst_rd_en", rd_enable, 0);
    check_eq("rst_peak_bin", peak_bin, 0);
    check_eq("rst_peak_mag", peak_mag, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Tone at bin 10 with its mirror image at bin 118.
    clear_vec();
    re_v[10]  = 1000;
    re_v[118] = 1000;
    re_v[3]   = 5;
    w0 = wr_pulses;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    @(negedge clk);
    while (fifo_srst && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq("srst_len", n, 4);
    check_eq("first_wr_en", fifo_wr_en, 1);
    run_frame("tone10", N - 1, -1, 10, 64'd1000000, 0);
    check_eq("tone10_writes", wr_pulses - w0, N);
    @(negedge clk);
    check_eq("tone10_done_pulse", done, 0);
    check_eq("tone10_done_cnt", done_cnt - d0, 1);
    check_eq("tone10_idle", busy, 0);
    @(posedge clk); #1;

    // Tie at bins 5 and 9; large DC, bin 64 and bin 100 are outside the half-spectrum.
    clear_vec();
    re_v[5]   = 300; im_v[5] = 400;
    re_v[9]   = 400; im_v[9] = 300;
    re_v[0]   = 30000;
    re_v[64]  = 20000;
    re_v[100] = 30000;
    pulse_start();
    run_frame("tie", N - 1, -1, 5, 64'd250000, 0);
    @(posedge clk); #1;

    // Upper boundary bin with negative components, neighbour above ignored.
    clear_vec();
    re_v[HALF_HI]     = -300; im_v[HALF_HI] = -400;
    re_v[HALF_HI + 1] = 600;
    re_v[1]           = -2;   im_v[1] = -2;
    pulse_start();
    run_frame("edge63", N - 1, -1, 63, 64'd250000, 0);
    @(posedge clk); #1;

    // Early tlast on bin 60.
    clear_vec();
    re_v[7] = 100;
    pulse_start();
    run_frame("tlast60", 60, -1, 7, 64'd10000, 1);
    @(posedge clk); #1;

    // fft_err pulse mid-frame.
    clear_vec();
    re_v[2] = 7; im_v[2] = -7;
    pulse_start();
    run_frame("ffterr", N - 1, 3, 2, 64'd98, 1);
    @(posedge clk); #1;

    // No FFT output: timeout after TO cycles of STREAM.
    d0 = done_cnt;
    pulse_start();
    k = 0;
    @(negedge clk);
    while (!rd_enable && k < 1000) begin
      k++;
      @(negedge clk);
    end
    n = 0;
    k = 0;
    while (rd_enable && k < TO + 100) begin
      n++;
      k++;
      @(negedge clk);
    end
    check_eq("timeout_len", n, TO);
    check_eq("timeout_done", done, 1);
    check_eq("timeout_err", err, 1);
    check_eq("timeout_mag", peak_mag, 0);
    @(posedge clk); #1;

    // Reset in the middle of capture, at wr_cnt = 50.
    d0 = done_cnt;
    w0 = wr_pulses;
    pulse_start();
    k = 0;
    n = 0;
    while (k < 50 && n < 200) begin
      @(negedge clk);
      n++;
      if (fifo_wr_en) k++;
    end
    @(posedge clk); #1;
    check_eq("midrst_writes", wr_pulses - w0, 50);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_wr_en", fifo_wr_en, 0);
    check_eq("midrst_srst", fifo_srst, 0);
    check_eq("midrst_rd_en", rd_enable, 0);
    check_eq("midrst_bin", peak_bin, 0);
    check_eq("midrst_err", err, 0);
    @(negedge clk);
    check_eq("midrst_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    clear_vec();
    re_v[20] = -1000; im_v[20] = 1000;
    w0 = wr_pulses;
    pulse_start();
    run_frame("postrst", N - 1, -1, 20, 64'd2000000, 0);
    check_eq("postrst_writes", wr_pulses - w0, N);
    @(posedge clk); #1;

    // Continuous mode, start arriving before the FFT wrapper is ready.
    d0 = done_cnt;
    fft_rst_done_i = 1'b0;
    continuous_i   = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    check_eq("cont_wait_busy", busy, 0);
    @(posedge clk); #1;
    fft_rst_done_i = 1'b1;
    @(negedge clk);
    check_eq("cont_pre_srst", fifo_srst, 0);
    @(negedge clk);
    check_eq("cont_clear_srst", fifo_srst, 1);
    clear_vec();
    im_v[3] = 2000;
    run_frame("cont1", N - 1, -1, 3, 64'd4000000, 0);
    @(negedge clk);
    check_eq("cont_rearm_srst", fifo_srst, 1);
    check_eq("cont_rearm_done", done, 0);
    @(posedge clk); #1;
    continuous_i = 1'b0;
    clear_vec();
    re_v[12] = 123;       im_v[12] = 456;
    re_v[40] = -(1 <<< (W - 1));
    im_v[40] = -(1 <<< (W - 1));
    run_frame("cont2", N - 1, -1, 40, 64'd140737488355328, 0);
    @(negedge clk);
    check_eq("cont_end_idle", busy, 0);
    check_eq("cont_done_cnt", done_cnt - d0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the capture -> FIFO -> fifo_reader -> FFT_WRAPPER chain. It clears the sample FIFO, gates exactly DATA_NUM ADC samples into it, and releases the reader into the FFT. It then scans the FFT output frame for the largest-magnitude bin in the positive half-spectrum and reports bin index and magnitude. It replaces hand-sequenced wr_en and tready control in the 2017E datapath.

## Interface
- DATA_NUM, 128: samples per frame and FFT length; power of two.
- FFT_WIDTH, 24: width of each FFT output component (re, im).
- CLR_CYCLES, 4: cycles fifo_srst is held.
- TIMEOUT, 4096: maximum cycles allowed in STREAM+SCAN.
- Reset rst is synchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request for one frame
- continuous  in  1  re-arm automatically after DONE
- adc_valid  in  1  sample strobe aligned with FIFO din
- fifo_srst  out  1  FIFO synchronous reset
- fifo_wr_en  out  1  FIFO write enable
- fifo_full  in  1  FIFO full flag
- fifo_data_count  in  10  FIFO occupancy
- rd_enable  out  1  ANDed into fifo_reader s_axis_tready
- fft_rst_done  in  1  FFT wrapper ready
- fft_tvalid, fft_tlast  in  1  FFT output beat qualifiers; m_axis tready is tied high
- fft_re, fft_im  in  FFT_WIDTH  signed FFT output components
- fft_err  in  1  OR of event_tlast_unexpected and event_tlast_missing
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle result strobe
- peak_bin  out  $clog2(DATA_NUM)  index of the peak bin
- peak_mag  out  2*FFT_WIDTH+1  re²+im² of the peak bin, unsigned
- err  out  1  fault flag for the reported frame; valid with done

## Operation
- States: IDLE, CLEAR, CAPTURE, STREAM, SCAN, DONE.
- IDLE: start sets a pending flag. Leave for CLEAR when pending && fft_rst_done. start seen in any other state is ignored.
- CLEAR: fifo_srst=1 for CLR_CYCLES cycles; clear the write counter, bin counter, peak registers and err; then go to CAPTURE.
- CAPTURE: fifo_wr_en = adc_valid && wr_cnt<DATA_NUM, combinational. wr_cnt increments on each write. fifo_full while writing sets err. Go to STREAM when wr_cnt==DATA_NUM && fifo_data_count==DATA_NUM.
- STREAM: rd_enable=1 and the timeout counter runs. Go to SCAN on the first fft_tvalid; that beat is also processed.
- SCAN: rd_enable stays 1 (the reader drains on its own). Per tvalid beat:
  - Stage 1 registers mag=re²+im² (signed products, unsigned sum, 2*FFT_WIDTH+1 bits) with its bin index.
  - Stage 2 compares against the running peak, only for bins 1..DATA_NUM/2-1.
  - A beat updates the peak only if its mag is strictly greater, so on ties the lowest bin wins.
  - fft_tlast ends the frame. If tlast arrives on bin != DATA_NUM-1, or fft_err rises anywhere in STREAM or SCAN, set err.
- Timeout reached in STREAM or SCAN: set err and go to DONE with the current peak registers.
- DONE: done=1 for one cycle and peak_bin/peak_mag are updated.
  - If continuous=1, go to CLEAR.
  - Otherwise go to IDLE and clear pending.
- peak_bin, peak_mag and err hold their values until the next DONE.

## Timing
- Reset values: fifo_srst=0, fifo_wr_en=0, rd_enable=0, busy=0, done=0, peak_bin=0, peak_mag=0, err=0; state=IDLE; pending cleared.
- rst in any state returns to IDLE within one cycle. Any frame in flight is discarded and no done is issued.
- start to first possible fifo_wr_en: 1 (IDLE) + CLR_CYCLES cycles, given fft_rst_done=1.
- Exactly DATA_NUM writes per frame; fifo_wr_en is never high outside CAPTURE.
- done rises 2 cycles after the tlast beat: one cycle for the magnitude stage, one for compare/commit.
- A beat arriving in the same cycle as tlast is processed normally.
- Timeout counter is cleared on entry to STREAM; err on timeout is flagged in the DONE cycle.

## Structure
- Package fft_ctrl_pkg holds:
  - the state enum;
  - BIN_W=$clog2(DATA_NUM);
  - MAG_W=2*FFT_WIDTH+1;
  - the half-spectrum bounds (1 and DATA_NUM/2-1).
- Sub-module fft_peak_tracker holds the two-stage magnitude/compare pipeline: inputs tvalid, tlast, re, im, clear; outputs peak_bin, peak_mag, frame_end.
- The FSM, counters and FIFO/reader gating stay in fft_frame_ctrl.

## Test plan
- Tone in bin 10: 128-sample sine loaded through the real FIFO, fifo_reader and FFT -> done once, peak_bin=10, err=0, exactly 128 fifo_wr_en pulses.
- Injected frame with equal maximum mag at bins 5 and 9 -> peak_bin=5. A large value at bin 0 or bin 100 is ignored.
- fft_tlast injected on bin 60 -> done 2 cycles later, err=1.
- FFT output held off with fft_tvalid=0 -> err=1 and done after TIMEOUT cycles in STREAM.
- rst pulsed during CAPTURE at wr_cnt=50 -> all outputs return to reset values the next cycle; a following start yields a clean frame.
- continuous=1 with start before fft_rst_done -> first CLEAR begins the cycle after fft_rst_done rises, then back-to-back frames with done once per frame and fifo_srst between them.
